// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 2-flop synchroniser, oversampled mid-bit sampling.
// Ports: clock, nreset (async low), sdata_rx_in -> data_rx_out, valid_rx_out,
//   frame_err_out, busy_rx_out (+ parity_err_out with UART_RX_PARITY_EN, even parity).
module uart_rx #(
  parameter int BYTESIZES    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int BAUDRATE     = 115200,
  parameter int CLOCK_INPUT  = 50_000_000
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 sdata_rx_in,
  output logic [BYTESIZES-1:0] data_rx_out,
  output logic                 valid_rx_out,
  output logic                 frame_err_out,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_out,
`endif
  output logic                 busy_rx_out
);

  localparam int DIV_RAW = CLOCK_INPUT / (BAUDRATE * OVERSAMPLING);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = $clog2(DIV) + 1;
  localparam int SW      = $clog2(OVERSAMPLING) + 1;
  localparam int BW      = $clog2(BYTESIZES) + 1;

  localparam logic [TW-1:0] TICK_MAX  = TW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] SAMP_FULL = SW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BYTESIZES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT
  } state_t;

  state_t r_state, w_state_nxt;

  logic                 r_sync1, r_sync2, r_rx_d;
  logic [TW-1:0]        r_tick;
  logic [SW-1:0]        r_samp, w_samp_nxt;
  logic [BW-1:0]        r_bit, w_bit_nxt;
  logic [BYTESIZES-1:0] r_shift;
  logic                 w_rx_s, w_fall, w_tick;
  logic                 w_tick_clr, w_shift_en;
  logic                 w_done_ok, w_done_err;
`ifdef UART_RX_PARITY_EN
  logic                 r_par, w_par_en;
`endif

  assign w_rx_s      = r_sync2;
  assign w_fall      = r_rx_d & ~r_sync2;
  assign w_tick      = (r_tick == TICK_MAX);
  assign busy_rx_out = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= sdata_rx_in;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // Tick phase restarts at the start edge so the centre count is aligned.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)         r_tick <= '0;
    else if (w_tick_clr) r_tick <= '0;
    else if (w_tick)     r_tick <= '0;
    else                 r_tick <= r_tick + TW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_clr  = 1'b0;
    w_samp_nxt  = r_samp;
    w_bit_nxt   = r_bit;
    w_shift_en  = 1'b0;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en    = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_tick_clr  = 1'b1;
          w_samp_nxt  = '0;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_samp == SAMP_HALF) begin
            w_samp_nxt = '0;
            if (!w_rx_s) begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_samp_nxt = r_samp + SW'(1);
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_samp == SAMP_FULL) begin
            w_samp_nxt = '0;
            w_shift_en = 1'b1;
            if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_nxt = r_bit + BW'(1);
            end
          end else begin
            w_samp_nxt = r_samp + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          if (r_samp == SAMP_FULL) begin
            w_samp_nxt  = '0;
            w_par_en    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_samp_nxt = r_samp + SW'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_samp == SAMP_FULL) begin
            w_samp_nxt = '0;
            if (w_rx_s) begin
              w_done_ok   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_done_err  = 1'b1;
              w_state_nxt = S_WAIT;
            end
          end else begin
            w_samp_nxt = r_samp + SW'(1);
          end
        end
      end
      S_WAIT: begin
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
      r_samp  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_samp  <= w_samp_nxt;
      r_bit   <= w_bit_nxt;
      if (w_shift_en)
        r_shift <= {w_rx_s, r_shift[BYTESIZES-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)       r_par <= 1'b0;
    else if (w_par_en) r_par <= w_rx_s;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) parity_err_out <= 1'b0;
    else         parity_err_out <= w_done_ok & (^r_shift ^ r_par);
  end
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      data_rx_out   <= '0;
      valid_rx_out  <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      valid_rx_out  <= w_done_ok;
      frame_err_out <= w_done_err;
      if (w_done_ok) data_rx_out <= r_shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vectors and corner sequences for uart_rx.
// Pulses are counted by a monitor sampling on the falling clock edge.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, ferr_o, busy_o;
`ifdef UART_RX_PARITY_EN
  logic       perr_o;
`endif

  uart_rx dut (
    .clock        (clock),
    .nreset       (nreset),
    .sdata_rx_in  (rx),
    .data_rx_out  (data_o),
    .valid_rx_out (valid_o),
    .frame_err_out(ferr_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_out(perr_o),
`endif
    .busy_rx_out  (busy_o)
  );

  always #5 clock = ~clock;

  localparam int BC  = 432;
  localparam int LAT = 4107;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int v_cnt, f_cnt, p_cnt, both_cnt, busy_bad;
  int last_v_cyc, t_start;
  logic [7:0] dq[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid_o) begin
      v_cnt++;
      last_v_cyc = cyc;
      dq.push_back(data_o);
      if (busy_o) busy_bad++;
    end
    if (ferr_o) f_cnt++;
    if (valid_o && ferr_o) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (perr_o) p_cnt++;
`endif
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic clr();
    v_cnt = 0; f_cnt = 0; p_cnt = 0;
    dq.delete();
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Leaves the line at the stop level after stop_bits periods.
  task automatic send_frame(input logic [7:0] d, input int bc,
                            input logic stop_lvl, input int stop_bits,
                            input int has_par, input logic pv);
    @(negedge clock);
    rx = 1'b0;
    t_start = cyc;
    wait_n(bc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_n(bc);
    end
    if (has_par != 0) begin
      rx = pv;
      wait_n(bc);
    end
    rx = stop_lvl;
    wait_n(bc * stop_bits);
  endtask

  typedef struct {
    logic [7:0] d;
    int         bc;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_d;
    int         exp_lat;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{8'hA5, 432, 1, 0, 8'hA5, LAT};
    vt[1] = '{8'h5A, 421, 1, 0, 8'h5A, LAT};
    vt[2] = '{8'h81, 443, 1, 0, 8'h81, LAT};
    vt[3] = '{8'hC3, 432, 1, 0, 8'hC3, LAT};
    both_cnt = 0; busy_bad = 0; last_v_cyc = 0; t_start = 0;
    clr();

    wait_n(4);
    chk("rst_data", int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_ferr", int'(ferr_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    nreset = 1'b1;
    wait_n(20);

    // Short low glitch: start check at centre must reject it.
    clr();
    rx = 1'b0;
    wait_n(50);
    chk("glitch_busy_hi", int'(busy_o), 1);
    wait_n(50);
    rx = 1'b1;
    wait_n(300);
    chk("glitch_valid", v_cnt, 0);
    chk("glitch_ferr", f_cnt, 0);
    chk("glitch_busy_lo", int'(busy_o), 0);

    foreach (vt[k]) begin
      clr();
      send_frame(vt[k].d, vt[k].bc, 1'b1, 1, 0, 1'b0);
      wait_n(vt[k].bc);
      chk($sformatf("vec%0d_valid", k), v_cnt, vt[k].exp_v);
      chk($sformatf("vec%0d_ferr", k), f_cnt, vt[k].exp_f);
      chk($sformatf("vec%0d_data", k), int'(data_o), int'(vt[k].exp_d));
      chk($sformatf("vec%0d_lat", k), last_v_cyc - t_start, vt[k].exp_lat);
      chk($sformatf("vec%0d_busy", k), int'(busy_o), 0);
    end

    // Stop bit low, line stuck low for two bit periods.
    clr();
    send_frame(8'h3C, BC, 1'b0, 1, 0, 1'b0);
    wait_n(BC / 2);
    chk("ferr_busy_mid", int'(busy_o), 1);
    wait_n(BC / 2);
    chk("ferr_busy_end", int'(busy_o), 1);
    rx = 1'b1;
    wait_n(10);
    chk("ferr_busy_lo", int'(busy_o), 0);
    chk("ferr_pulses", f_cnt, 1);
    chk("ferr_valid", v_cnt, 0);
    chk("ferr_data_kept", int'(data_o), 8'hC3);
    wait_n(BC);

    // Back-to-back frames, nominal and 2.5% fast.
    for (int r = 0; r < 2; r++) begin
      int bc;
      bc = (r == 0) ? 432 : 421;
      clr();
      send_frame(8'h00, bc, 1'b1, 1, 0, 1'b0);
      send_frame(8'hFF, bc, 1'b1, 1, 0, 1'b0);
      wait_n(bc);
      chk($sformatf("b2b%0d_valid", r), v_cnt, 2);
      chk($sformatf("b2b%0d_ferr", r), f_cnt, 0);
      chk($sformatf("b2b%0d_d0", r),
          (dq.size() > 0) ? int'(dq[0]) : -1, 8'h00);
      chk($sformatf("b2b%0d_d1", r),
          (dq.size() > 1) ? int'(dq[1]) : -1, 8'hFF);
    end

    // Reset in the middle of data bit 4 of 0x5A.
    clr();
    begin
      logic [7:0] d;
      d = 8'h5A;
      @(negedge clock);
      rx = 1'b0;
      wait_n(BC);
      for (int i = 0; i < 4; i++) begin
        rx = d[i];
        wait_n(BC);
      end
      rx = d[4];
      wait_n(BC / 2);
      nreset = 1'b0;
      #1;
      chk("rst_mid_data", int'(data_o), 0);
      chk("rst_mid_busy", int'(busy_o), 0);
      chk("rst_mid_valid", int'(valid_o), 0);
      wait_n(BC / 2);
      for (int i = 5; i < 8; i++) begin
        rx = d[i];
        wait_n(BC);
      end
      rx = 1'b1;
      wait_n(BC);
      nreset = 1'b1;
      wait_n(BC);
    end
    chk("rst_abort_valid", v_cnt, 0);
    chk("rst_abort_ferr", f_cnt, 0);
    send_frame(8'h81, BC, 1'b1, 1, 0, 1'b0);
    wait_n(BC);
    chk("rst_next_valid", v_cnt, 1);
    chk("rst_next_data", int'(data_o), 8'h81);

`ifdef UART_RX_PARITY_EN
    clr();
    send_frame(8'h07, BC, 1'b1, 1, 1, 1'b1);
    wait_n(BC);
    chk("par1_valid", v_cnt, 1);
    chk("par1_perr", p_cnt, 0);
    chk("par1_data", int'(data_o), 8'h07);
    clr();
    send_frame(8'h07, BC, 1'b1, 1, 1, 1'b0);
    wait_n(BC);
    chk("par0_valid", v_cnt, 1);
    chk("par0_perr", p_cnt, 1);
    chk("par0_data", int'(data_o), 8'h07);
`endif

    chk("excl_valid_ferr", both_cnt, 0);
    chk("busy_with_valid", busy_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive channel; the counterpart of the team's uart_tx.
- Deserialises an asynchronous 8N1 serial line into parallel words, using an internal oversampling tick and mid-bit sampling.
- Presents each received word with a one-clock valid pulse to the downstream FPGA logic.
- Flags a framing error when the stop bit is wrong.

Parameters:
- BYTESIZES, 8, data bits per frame, sent LSB first.
- OVERSAMPLING, 16, ticks per bit period; must be even and at least 4.
- BAUDRATE, 115200, line bit rate in bit/s.
- CLOCK_INPUT, 50_000_000, frequency of clock in Hz.

Ports:
- clock  input  1  system clock; every flop is on its rising edge.
- nreset  input  1  asynchronous active-low reset.
- sdata_rx_in  input  1  serial line; idles high; asynchronous to clock.
- data_rx_out  output  BYTESIZES  last correctly framed word; held until the next good frame.
- valid_rx_out  output  1  one-clock pulse when data_rx_out updates.
- frame_err_out  output  1  one-clock pulse when the stop bit is sampled low.
- busy_rx_out  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (asynchronous, active low): data_rx_out=0, valid_rx_out=0, frame_err_out=0, busy_rx_out=0. Synchroniser flops reset to 1. FSM goes to IDLE; all counters go to 0. Reset mid-frame aborts the frame with no output pulse.
- Synchroniser: 2-flop chain on sdata_rx_in. Every decision uses the synchronised bit rx_s, which lags the line by 2 clocks.
- Tick generator:
  - Divider DIV = CLOCK_INPUT/(BAUDRATE*OVERSAMPLING), integer floor, clamped to a minimum of 1.
  - Counter runs 0..DIV-1; tick is high for one clock at DIV-1.
  - Counter is cleared on the IDLE->START transition so start sampling is phase-aligned.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: busy_rx_out=0. On rx_s high->low, go to START and clear the tick counter and the sample counter.
  - START: count OVERSAMPLING/2 ticks, which is the bit centre.
    - rx_s=0 at centre: go to DATA, clear sample counter and bit index.
    - rx_s=1 at centre: false start; return to IDLE with no pulse.
  - DATA: sample rx_s every OVERSAMPLING ticks, at each bit centre. Shift right into the shift register so the first bit received ends as LSB. After BYTESIZES samples, go to STOP.
  - STOP: sample after OVERSAMPLING ticks.
    - rx_s=1: on the next clock, load data_rx_out from the shift register and pulse valid_rx_out; go to IDLE.
    - rx_s=0: on the next clock, pulse frame_err_out; data_rx_out is unchanged; go to WAIT_IDLE.
  - WAIT_IDLE: break/line-stuck handling. Stay until rx_s=1, then go to IDLE. No start detection occurs here.
- Back-to-back frames: IDLE is re-entered about half a bit before the stop bit ends, so a start edge directly after the stop bit is captured.
- Pulse exclusivity: valid_rx_out and frame_err_out are never high in the same cycle.
- Latency: the pulse arrives 1 clock after the stop-centre tick. That is about (BYTESIZES+1.5) bit periods plus 3 clocks after the start edge on the pin.
- Arithmetic: tick counter width $clog2(DIV)+1; sample counter width $clog2(OVERSAMPLING)+1; bit index width $clog2(BYTESIZES)+1. No counter wraps within a frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Frame is start, data, even-parity bit, stop.
  - A PARITY state between DATA and STOP samples the parity bit at its centre.
  - An extra output port parity_err_out (1 bit, reset 0) is present. It pulses in the same clock as valid_rx_out when the XOR of the data bits and the parity bit equals 1.
  - Data is still delivered on a parity error.
  - A framing error overrides: frame_err_out pulses and parity_err_out does not.
- When undefined: no PARITY state, no parity_err_out port; the frame is 8N1 exactly as above.

Test Plan:
- Defaults give DIV=27 and a bit period of 432 clocks.
- Send 0xA5 8N1 at 432 clocks/bit -> valid_rx_out pulses once, data_rx_out=0xA5, frame_err_out stays 0, busy_rx_out falls with the pulse.
- Low glitch of 100 clocks on an idle line -> START aborts at centre; no pulses; busy_rx_out returns to 0; FSM back in IDLE.
- Frame 0x3C with the stop bit driven low, line then high after 2 bit periods -> frame_err_out pulses once, data_rx_out keeps its previous value, no valid pulse, IDLE re-entered only after line high.
- Back-to-back 0x00 then 0xFF with no idle gap, then the same at 2.5% fast bit timing (421 clocks/bit) -> two valid pulses, data 0x00 then 0xFF, no errors.
- nreset asserted mid-data-bit 4 of a 0x5A frame, released, then a clean 0x81 frame -> outputs 0 immediately; no pulse for the aborted frame; 0x81 received correctly.
- With UART_RX_PARITY_EN, frames 0x07 with parity 1 and 0x07 with parity 0 -> first frame: valid with parity_err_out=0; second frame: valid with parity_err_out=1, data 0x07 both times.
